// File: rtl/decode_buffered_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_buffered_stage
// Purpose  : Instruction queue + decode/RF-read/imm-gen into a valid/ready ID/EX register.
// Revision : 1.0
// ============================================================================
module decode_buffered_stage #(
  parameter int PC_W     = 32,
  parameter int INSTR_W  = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int ALU_OP_W = 3,
  parameter int IMM_W    = 32,
  parameter int DEPTH    = 4,
  parameter int CNT_W    = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fe_valid_i,
  output logic                       fe_ready_o,
  input  logic [INSTR_W-1:0]         instr_i,
  input  logic [PC_W-1:0]            pc_plus1_i,
  input  logic [ADDR_W-1:0]          rf_waddr_i,
  input  logic [DATA_W-1:0]          rf_wdata_i,
  input  logic                       rf_we_i,
  input  logic                       flush_i,
  input  logic                       exe_ready_i,
  output logic                       exe_valid_o,
  output logic                       has_imm_o,
  output logic [ALU_OP_W-1:0]        alu_op_o,
  output logic                       alu_alt_o,
  output logic                       rf_we_o,
  output logic                       mem_we_o,
  output logic                       mem2rf_o,
  output logic                       branch_o,
  output logic                       check_eq_o,
  output logic [IMM_W-1:0]           imm32_o,
  output logic [DATA_W-1:0]          rf_data0_o,
  output logic [DATA_W-1:0]          rf_data1_o,
  output logic [ADDR_W-1:0]          rf_waddr_o,
  output logic [ADDR_W-1:0]          rf_src0_o,
  output logic [ADDR_W-1:0]          rf_src1_o,
  output logic [PC_W-1:0]            pc_plus1_o,
  output logic [$clog2(DEPTH):0]     q_count_o,
  output logic [CNT_W-1:0]           stall_cnt_o
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int QCNT_W = PTR_W + 1;
  localparam int NREG   = 1 << ADDR_W;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef struct packed {
    logic                has_imm;
    logic [ALU_OP_W-1:0] alu_op;
    logic                alu_alt;
    logic                rf_we;
    logic                mem_we;
    logic                mem2rf;
    logic                branch;
    logic                check_eq;
    logic [IMM_W-1:0]    imm;
    logic [DATA_W-1:0]   data0;
    logic [DATA_W-1:0]   data1;
    logic [ADDR_W-1:0]   waddr;
    logic [ADDR_W-1:0]   src0;
    logic [ADDR_W-1:0]   src1;
    logic [PC_W-1:0]     pc;
  } bundle_t;

  // ---------------------------------------------------------------- state
  logic [INSTR_W-1:0] q_instr_q [DEPTH];
  logic [INSTR_W-1:0] q_instr_d [DEPTH];
  logic [PC_W-1:0]    q_pc_q    [DEPTH];
  logic [PC_W-1:0]    q_pc_d    [DEPTH];
  logic [DATA_W-1:0]  rf_q      [NREG];
  logic [DATA_W-1:0]  rf_d      [NREG];

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [QCNT_W-1:0]  count_q, count_d;
  logic               valid_q, valid_d;
  bundle_t            out_q, out_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  // ---------------------------------------------------------------- control
  logic               push, pop, issue, load_use, src1_used, not_empty;
  logic [INSTR_W-1:0] head_instr;
  logic [PC_W-1:0]    head_pc;
  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic [11:0]        imm12;
  bundle_t            dec;

  assign not_empty  = (count_q != '0);
  assign fe_ready_o = (count_q != QCNT_W'(DEPTH));
  assign push       = fe_valid_i & fe_ready_o & ~flush_i;
  assign head_instr = q_instr_q[rd_ptr_q];
  assign head_pc    = q_pc_q[rd_ptr_q];
  assign opcode     = head_instr[6:0];
  assign funct3     = head_instr[14:12];

  // Decode of the queue head, including register read with WB write-through.
  always_comb begin
    dec          = '0;
    dec.src0     = head_instr[15 +: ADDR_W];
    dec.src1     = head_instr[20 +: ADDR_W];
    dec.waddr    = head_instr[7 +: ADDR_W];
    dec.pc       = head_pc;
    case (opcode)
      OPC_OP: begin
        dec.alu_op  = ALU_OP_W'(funct3);
        dec.alu_alt = head_instr[30];
        dec.rf_we   = 1'b1;
      end
      OPC_OP_IMM: begin
        dec.has_imm = 1'b1;
        dec.alu_op  = ALU_OP_W'(funct3);
        dec.alu_alt = (funct3 == 3'b101) & head_instr[30];
        dec.rf_we   = 1'b1;
      end
      OPC_LOAD: begin
        dec.has_imm = 1'b1;
        dec.rf_we   = 1'b1;
        dec.mem2rf  = 1'b1;
      end
      OPC_STORE: begin
        dec.has_imm = 1'b1;
        dec.mem_we  = 1'b1;
      end
      OPC_BRANCH: begin
        dec.has_imm  = 1'b1;
        dec.alu_alt  = 1'b1;
        dec.branch   = 1'b1;
        dec.check_eq = (funct3 == 3'b000);
      end
      default: ;
    endcase

    if (dec.mem_we)
      imm12 = {head_instr[31:25], head_instr[11:7]};
    else if (dec.branch)
      imm12 = {head_instr[31], head_instr[31], head_instr[7], head_instr[30:25], head_instr[11:9]};
    else
      imm12 = head_instr[31:20];
    dec.imm = {{(IMM_W-12){imm12[11]}}, imm12};

    dec.data0 = (rf_we_i && rf_waddr_i == dec.src0 && dec.src0 != '0) ? rf_wdata_i : rf_q[dec.src0];
    dec.data1 = (rf_we_i && rf_waddr_i == dec.src1 && dec.src1 != '0) ? rf_wdata_i : rf_q[dec.src1];
  end

  assign src1_used = ~dec.has_imm | dec.mem_we | dec.branch;
  assign load_use  = valid_q & out_q.mem2rf & (out_q.waddr != '0) &
                     ((dec.src0 == out_q.waddr) | (src1_used & (dec.src1 == out_q.waddr)));
  assign issue     = not_empty & ~load_use & (~valid_q | exe_ready_i);
  assign pop       = issue & ~flush_i;

  // ---------------------------------------------------------------- next state
  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      q_instr_d[e] = q_instr_q[e];
      q_pc_d[e]    = q_pc_q[e];
      if (push && wr_ptr_q == PTR_W'(e)) begin
        q_instr_d[e] = instr_i;
        q_pc_d[e]    = pc_plus1_i;
      end
    end
  end

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      rf_d[r] = rf_q[r];
      if (rf_we_i && r != 0 && rf_waddr_i == ADDR_W'(r))
        rf_d[r] = rf_wdata_i;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + QCNT_W'(push) - QCNT_W'(pop);
    end
  end

  // Fields are only reloaded on issue, so a stalled EXE sees a stable bundle.
  always_comb begin
    valid_d = valid_q;
    out_d   = out_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (issue) begin
      valid_d = 1'b1;
      out_d   = dec;
    end else if (exe_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (not_empty && load_use && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  // ---------------------------------------------------------------- registers
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int e = 0; e < DEPTH; e++) begin
        q_instr_q[e] <= '0;
        q_pc_q[e]    <= '0;
      end
      for (int r = 0; r < NREG; r++)
        rf_q[r] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      valid_q     <= 1'b0;
      out_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        q_instr_q[e] <= q_instr_d[e];
        q_pc_q[e]    <= q_pc_d[e];
      end
      for (int r = 0; r < NREG; r++)
        rf_q[r] <= rf_d[r];
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      valid_q     <= valid_d;
      out_q       <= out_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // ---------------------------------------------------------------- outputs
  assign exe_valid_o = valid_q;
  assign has_imm_o   = out_q.has_imm;
  assign alu_op_o    = out_q.alu_op;
  assign alu_alt_o   = out_q.alu_alt;
  assign rf_we_o     = out_q.rf_we;
  assign mem_we_o    = out_q.mem_we;
  assign mem2rf_o    = out_q.mem2rf;
  assign branch_o    = out_q.branch;
  assign check_eq_o  = out_q.check_eq;
  assign imm32_o     = out_q.imm;
  assign rf_data0_o  = out_q.data0;
  assign rf_data1_o  = out_q.data1;
  assign rf_waddr_o  = out_q.waddr;
  assign rf_src0_o   = out_q.src0;
  assign rf_src1_o   = out_q.src1;
  assign pc_plus1_o  = out_q.pc;
  assign q_count_o   = count_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_buffered_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_buffered_stage
// Purpose  : Directed self-checking bench for decode_buffered_stage.
// Revision : 1.0
// ============================================================================
module tb_decode_buffered_stage;

  localparam int CNT_W = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fe_valid = 1'b0;
  logic        fe_ready;
  logic [31:0] instr = '0;
  logic [31:0] pc_plus1 = '0;
  logic [4:0]  rf_waddr = '0;
  logic [31:0] rf_wdata = '0;
  logic        rf_we = 1'b0;
  logic        flush = 1'b0;
  logic        exe_ready = 1'b1;
  logic        exe_valid;
  logic        has_imm, alu_alt, rf_we_o, mem_we, mem2rf, branch, check_eq;
  logic [2:0]  alu_op;
  logic [31:0] imm32, rf_data0, rf_data1, pc_plus1_o;
  logic [4:0]  rf_waddr_o, rf_src0, rf_src1;
  logic [2:0]  q_count;
  logic [CNT_W-1:0] stall_cnt;

  int n_vec  = 0;
  int n_miss = 0;

  decode_buffered_stage #(.CNT_W(CNT_W)) u_dut (
    .clk(clk), .reset(reset),
    .fe_valid_i(fe_valid), .fe_ready_o(fe_ready),
    .instr_i(instr), .pc_plus1_i(pc_plus1),
    .rf_waddr_i(rf_waddr), .rf_wdata_i(rf_wdata), .rf_we_i(rf_we),
    .flush_i(flush), .exe_ready_i(exe_ready), .exe_valid_o(exe_valid),
    .has_imm_o(has_imm), .alu_op_o(alu_op), .alu_alt_o(alu_alt),
    .rf_we_o(rf_we_o), .mem_we_o(mem_we), .mem2rf_o(mem2rf),
    .branch_o(branch), .check_eq_o(check_eq), .imm32_o(imm32),
    .rf_data0_o(rf_data0), .rf_data1_o(rf_data1), .rf_waddr_o(rf_waddr_o),
    .rf_src0_o(rf_src0), .rf_src1_o(rf_src1), .pc_plus1_o(pc_plus1_o),
    .q_count_o(q_count), .stall_cnt_o(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] ins, input logic [31:0] pc);
    fe_valid = 1'b1;
    instr    = ins;
    pc_plus1 = pc;
    tick;
    fe_valid = 1'b0;
  endtask

  function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'h13};
  endfunction

  function automatic logic [31:0] enc_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'h00, rs2, rs1, 3'b000, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_lw(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'h000, rs1, 3'b010, rd, 7'h03};
  endfunction

  initial begin
    // reset state
    tick; tick;
    reset = 1'b0;
    tick;
    check_vec("rst_count", q_count, 0);
    check_vec("rst_valid", exe_valid, 0);
    check_vec("rst_ready", fe_ready, 1);
    check_vec("rst_stall", stall_cnt, 0);
    check_vec("rst_imm", imm32, 0);

    // stream: addi x1,x0,5 ; add x2,x1,x1
    exe_ready = 1'b1;
    check_vec("enc_addi", enc_addi(1, 0, 5), 32'h0050_0093);
    push(enc_addi(1, 0, 5), 1);
    push(enc_add(2, 1, 1), 2);
    check_vec("s1_valid", exe_valid, 1);
    check_vec("s1_imm", imm32, 5);
    check_vec("s1_hasimm", has_imm, 1);
    check_vec("s1_waddr", rf_waddr_o, 1);
    check_vec("s1_pc", pc_plus1_o, 1);
    tick;
    check_vec("s2_valid", exe_valid, 1);
    check_vec("s2_src0", rf_src0, 1);
    check_vec("s2_src1", rf_src1, 1);
    check_vec("s2_waddr", rf_waddr_o, 2);
    check_vec("s2_hasimm", has_imm, 0);
    tick;
    check_vec("s3_bubble", exe_valid, 0);
    check_vec("s3_count", q_count, 0);

    // backpressure: 5 pushes into a 4-deep queue with EXE stalled
    exe_ready = 1'b0;
    for (int k = 1; k <= 5; k++) push(enc_addi(5'(k), 0, 12'(k)), 32'(10 + k));
    check_vec("bp_count", q_count, 4);
    check_vec("bp_ready", fe_ready, 0);
    check_vec("bp_valid", exe_valid, 1);
    check_vec("bp_hold_imm", imm32, 1);
    push(enc_addi(6, 0, 6), 16);
    check_vec("bp_drop_count", q_count, 4);
    check_vec("bp_hold_imm2", imm32, 1);
    check_vec("bp_hold_pc", pc_plus1_o, 11);
    exe_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      tick;
      check_vec("bp_order_imm", imm32, k);
      check_vec("bp_order_pc", pc_plus1_o, 10 + k);
    end
    tick;
    check_vec("bp_end_valid", exe_valid, 0);
    check_vec("bp_end_count", q_count, 0);

    // load-use: lw x3 ; add x4,x3,x0
    push(enc_lw(3, 0), 20);
    push(enc_add(4, 3, 0), 21);
    check_vec("lu_lw_mem2rf", mem2rf, 1);
    tick;
    check_vec("lu_bubble", exe_valid, 0);
    check_vec("lu_stall", stall_cnt, 1);
    tick;
    check_vec("lu_issue", exe_valid, 1);
    check_vec("lu_waddr", rf_waddr_o, 4);
    tick;
    // lw x0 ; add x5,x0,x0 -> no bubble
    push(enc_lw(0, 0), 22);
    push(enc_add(5, 0, 0), 23);
    tick;
    check_vec("lu0_valid", exe_valid, 1);
    check_vec("lu0_waddr", rf_waddr_o, 5);
    check_vec("lu0_stall", stall_cnt, 1);
    tick;

    // write-through
    push(enc_addi(8, 7, 0), 30);
    rf_we = 1'b1; rf_waddr = 7; rf_wdata = 32'hDEAD;
    tick;
    rf_we = 1'b0;
    check_vec("wt_x7", rf_data0, 32'hDEAD);
    tick;
    push(enc_addi(8, 0, 0), 31);
    rf_we = 1'b1; rf_waddr = 0; rf_wdata = 32'hDEAD;
    tick;
    rf_we = 1'b0;
    check_vec("wt_x0", rf_data0, 0);
    tick;
    push(enc_addi(9, 7, 0), 32);
    tick;
    check_vec("rf_x7", rf_data0, 32'hDEAD);
    tick;

    // flush: 1 in output register, 3 queued, flush with a push
    exe_ready = 1'b0;
    for (int k = 0; k < 4; k++) push(enc_addi(10, 0, 12'(16 + k)), 32'(50 + k));
    check_vec("fl_pre_count", q_count, 3);
    check_vec("fl_pre_valid", exe_valid, 1);
    fe_valid = 1'b1; instr = enc_addi(11, 0, 12'h0AA); pc_plus1 = 60; flush = 1'b1;
    tick;
    fe_valid = 1'b0; flush = 1'b0;
    check_vec("fl_count", q_count, 0);
    check_vec("fl_valid", exe_valid, 0);
    check_vec("fl_ready", fe_ready, 1);
    exe_ready = 1'b1;
    tick; tick;
    check_vec("fl_absent_valid", exe_valid, 0);
    check_vec("fl_absent_count", q_count, 0);

    // mid-operation reset
    exe_ready = 1'b0;
    push(enc_addi(1, 0, 1), 70);
    push(enc_addi(2, 0, 2), 71);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check_vec("mr_count", q_count, 0);
    check_vec("mr_valid", exe_valid, 0);
    check_vec("mr_stall", stall_cnt, 0);
    check_vec("mr_imm", imm32, 0);

    // stall counter saturation with CNT_W=2
    push(enc_lw(3, 0), 40);
    push(enc_add(4, 3, 0), 41);
    for (int i = 1; i <= 5; i++) begin
      tick;
      check_vec("sat_stall", stall_cnt, (i > 3) ? 3 : i);
    end
    check_vec("sat_valid", exe_valid, 1);
    check_vec("sat_hold_waddr", rf_waddr_o, 3);
    check_vec("sat_count", q_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
